// File: rtl/core_ex_mem_responder.sv
// Single-port memory responder for an execute/memory stage: accepts one request,
// waits LATENCY cycles, performs the word access and then holds the response until it is taken.
module core_ex_mem_responder #(
  parameter int XLEN        = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [7:0]      req_wmask,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err
);

  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;

  logic            wen_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      wmask_q;

  logic [XLEN-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;

  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            do_access;
  logic            mem_we;
  logic            acc_wen;
  logic [XLEN-1:0] acc_addr;
  logic [XLEN-1:0] acc_wdata;
  logic [3:0]      acc_wmask;
  logic [AW-1:0]   acc_idx;
  logic            acc_oor;
  logic            unused_bits;

  assign accept = (state_q == IDLE) && req_valid;

  // With LATENCY=1 the access happens on the accept edge itself, so the
  // operands come straight from the request port instead of the latches.
  always_comb begin
    if (state_q == IDLE) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask[3:0];
    end else begin
      acc_wen   = wen_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_wmask = wmask_q;
    end
  end

  assign acc_idx     = acc_addr[AW+1:2];
  assign acc_oor     = (acc_addr >> (AW + 2)) != '0;
  assign mem_we      = do_access && acc_wen && !acc_oor;
  assign unused_bits = ^{req_wmask[7:4], acc_addr[1:0]};

  // NOTE: every variable written here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (LATENCY == 1) begin
            do_access = 1'b1;
            cnt_d     = 4'd0;
            state_d   = RESP;
          end else begin
            cnt_d   = CNT_INIT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_d == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Response registers only move on an access, which keeps them stable
  // for the whole time the response is waiting on rsp_ready.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (do_access) begin
      err_d   = acc_oor;
      rdata_d = (!acc_wen && !acc_oor) ? XLEN'(mem[acc_idx]) : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= 4'd0;
    end else if (accept) begin
      wen_q   <= req_wen;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      wmask_q <= req_wmask[3:0];
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; a store pending
  // in WAIT is discarded because reset clears the state that enables mem_we.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_wmask[b]) begin
          mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_core_ex_mem_responder.sv
// Scoreboard bench: drivers push expected responses, per-instance monitors
// pop and compare on every completed response handshake.
module tb_core_ex_mem_responder;

  localparam int XLEN = 32;
  localparam int LAT0 = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;

  logic            req_valid, req_ready, req_wen, rsp_valid, rsp_ready, rsp_err;
  logic [XLEN-1:0] req_addr, req_wdata, rsp_rdata;
  logic [7:0]      req_wmask;

  logic            req_valid1, req_ready1, req_wen1, rsp_valid1, rsp_ready1, rsp_err1;
  logic [XLEN-1:0] req_addr1, req_wdata1, rsp_rdata1;
  logic [7:0]      req_wmask1;

  always #5 clk = ~clk;

  core_ex_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(1024), .LATENCY(LAT0)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  core_ex_mem_responder #(.XLEN(XLEN), .DEPTH_WORDS(1024), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid1), .req_ready(req_ready1), .req_wen(req_wen1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wmask(req_wmask1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t m0_e, m1_e;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  int acc0    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (req_valid && req_ready) acc0++;
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (q0.size() == 0) begin
        check("rsp0_unexpected", 32'd1, 32'd0);
      end else begin
        m0_e = q0.pop_front();
        check({m0_e.name, "_rdata"}, rsp_rdata, m0_e.rdata);
        check({m0_e.name, "_err"}, 32'(rsp_err), 32'(m0_e.err));
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid1 && rsp_ready1) begin
      if (q1.size() == 0) begin
        check("rsp1_unexpected", 32'd1, 32'd0);
      end else begin
        m1_e = q1.pop_front();
        check({m1_e.name, "_rdata"}, rsp_rdata1, m1_e.rdata);
        check({m1_e.name, "_err"}, 32'(rsp_err1), 32'(m1_e.err));
      end
    end
  end

  // One complete transaction on the LATENCY=2 instance with rsp_ready held high.
  task automatic do_req(input string name, input logic wen, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [7:0] wmask,
                        input logic [31:0] exp_rdata, input logic exp_err);
    int k;
    req_wen   = wen;
    req_addr  = addr;
    req_wdata = wdata;
    req_wmask = wmask;
    req_valid = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (!req_ready && k < 50);
    check({name, "_acc_wait"}, 32'(k), 32'd1);
    q0.push_back('{rdata: exp_rdata, err: exp_err, name: name});
    @(posedge clk); #1;
    req_valid = 1'b0;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 50);
    check({name, "_lat"}, 32'(k), 32'(LAT0));
    @(posedge clk); #1;
  endtask

  task automatic wait_rsp_valid(input string name);
    int k;
    k = 0;
    do begin @(negedge clk); k++; end while (!rsp_valid && k < 50);
    if (!rsp_valid) check({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  logic        v_wen  [4];
  logic [31:0] v_addr [4];
  logic [31:0] v_wdata[4];
  logic [31:0] v_exp  [4];
  int          t_acc  [4];

  initial begin
    int a0;
    int k;
    req_valid = 0; req_wen = 0; req_addr = '0; req_wdata = '0; req_wmask = '0; rsp_ready = 1;
    req_valid1 = 0; req_wen1 = 0; req_addr1 = '0; req_wdata1 = '0; req_wmask1 = '0; rsp_ready1 = 1;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", 32'(rsp_err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic store/load, byte masking, unaligned address, empty mask
    do_req("st_full",   1'b1, 32'h10,  32'hAABBCCDD, 8'h0F, 32'h0, 1'b0);
    do_req("ld_full",   1'b0, 32'h10,  32'h0,        8'h00, 32'hAABBCCDD, 1'b0);
    do_req("st_byte1",  1'b1, 32'h10,  32'h11223344, 8'h02, 32'h0, 1'b0);
    do_req("ld_unal",   1'b0, 32'h12,  32'h0,        8'h00, 32'hAABB33DD, 1'b0);
    do_req("st_nomask", 1'b1, 32'h10,  32'hFFFFFFFF, 8'hF0, 32'h0, 1'b0);
    do_req("ld_nomask", 1'b0, 32'h10,  32'h0,        8'h00, 32'hAABB33DD, 1'b0);
    do_req("st_w0",     1'b1, 32'h0,   32'h01020304, 8'h0F, 32'h0, 1'b0);
    do_req("st_last",   1'b1, 32'hFFC, 32'hDEADBEEF, 8'h0F, 32'h0, 1'b0);
    do_req("st_last_m9",1'b1, 32'hFFD, 32'h11223344, 8'h09, 32'h0, 1'b0);
    do_req("ld_last",   1'b0, 32'hFFF, 32'h0,        8'h00, 32'h11ADBE44, 1'b0);

    // Out-of-range accesses; 0x1000 and 0x80000000 alias word 0 if unchecked
    do_req("ld_oor",    1'b0, 32'h1000,     32'h0,        8'h00, 32'h0, 1'b1);
    do_req("st_oor",    1'b1, 32'h1000,     32'h55555555, 8'h0F, 32'h0, 1'b1);
    do_req("st_oor_hi", 1'b1, 32'h80000010, 32'h66666666, 8'h0F, 32'h0, 1'b1);
    do_req("ld_w0",     1'b0, 32'h0,        32'h0,        8'h00, 32'h01020304, 1'b0);
    do_req("ld_w10",    1'b0, 32'h10,       32'h0,        8'h00, 32'hAABB33DD, 1'b0);
    do_req("ld_last2",  1'b0, 32'hFFC,      32'h0,        8'h00, 32'h11ADBE44, 1'b0);

    // Backpressure with req_valid held high
    a0 = acc0;
    rsp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 32'h10; req_wmask = 8'h00; req_valid = 1'b1;
    q0.push_back('{rdata: 32'hAABB33DD, err: 1'b0, name: "bp1"});
    q0.push_back('{rdata: 32'hAABB33DD, err: 1'b0, name: "bp2"});
    wait_rsp_valid("bp_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hAABB33DD);
      check("bp_err", 32'(rsp_err), 32'd0);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    check("bp_accepts_held", 32'(acc0 - a0), 32'd1);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("bp_accepts_after", 32'(acc0 - a0), 32'd2);
    wait_rsp_valid("bp_second");
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    check("bp_accepts_final", 32'(acc0 - a0), 32'd2);

    // Reset during WAIT discards the pending store
    do_req("st_20", 1'b1, 32'h20, 32'hCAFEF00D, 8'h0F, 32'h0, 1'b0);
    do_req("ld_20", 1'b0, 32'h20, 32'h0,        8'h00, 32'hCAFEF00D, 1'b0);
    req_wen = 1'b1; req_addr = 32'h20; req_wdata = 32'h99999999; req_wmask = 8'h0F; req_valid = 1'b1;
    @(negedge clk);
    check("wr_rst_acc_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("wait_rst_req_ready", 32'(req_ready), 32'd1);
    check("wait_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("wait_rst_rdata", rsp_rdata, 32'd0);
    check("wait_rst_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    do_req("ld_20_kept", 1'b0, 32'h20, 32'h0, 8'h00, 32'hCAFEF00D, 1'b0);

    // Reset during RESP drops the response
    rsp_ready = 1'b0;
    req_wen = 1'b0; req_addr = 32'h20; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp_valid("resp_rst");
    #1 rst_n = 1'b0;
    #1;
    check("resp_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("resp_rst_rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    do_req("ld_20_again", 1'b0, 32'h20, 32'h0, 8'h00, 32'hCAFEF00D, 1'b0);

    // LATENCY=1 instance: back-to-back requests accepted every 2 cycles
    v_wen[0] = 1'b1; v_addr[0] = 32'h0; v_wdata[0] = 32'h0BADF00D; v_exp[0] = 32'h0;
    v_wen[1] = 1'b1; v_addr[1] = 32'h4; v_wdata[1] = 32'h13572468; v_exp[1] = 32'h0;
    v_wen[2] = 1'b0; v_addr[2] = 32'h0; v_wdata[2] = 32'h0;        v_exp[2] = 32'h0BADF00D;
    v_wen[3] = 1'b0; v_addr[3] = 32'h6; v_wdata[3] = 32'h0;        v_exp[3] = 32'h13572468;
    req_wen1 = v_wen[0]; req_addr1 = v_addr[0]; req_wdata1 = v_wdata[0]; req_wmask1 = 8'h0F;
    req_valid1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      k = 0;
      do begin @(negedge clk); k++; end while (!req_ready1 && k < 50);
      if (!req_ready1) check("l1_acc_timeout", 32'd0, 32'd1);
      q1.push_back('{rdata: v_exp[i], err: 1'b0, name: $sformatf("l1_req%0d", i)});
      @(posedge clk); #1;
      t_acc[i] = cyc;
      if (i < 3) begin
        req_wen1 = v_wen[i+1]; req_addr1 = v_addr[i+1]; req_wdata1 = v_wdata[i+1];
      end else begin
        req_valid1 = 1'b0;
      end
    end
    for (int i = 1; i < 4; i++) check($sformatf("l1_spacing%0d", i), 32'(t_acc[i] - t_acc[i-1]), 32'd2);
    repeat (4) @(posedge clk);
    #1;

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
